// File: rtl/inv_key_scheduler.sv
// AES-128 decryption key source: expands the cipher key to round key 10, then streams keys 10..0.
// Latency: start accepted at edge 0, first key (idx 10) valid from edge 11; one key per cycle after that.
// Backpressure: key_ready low in EMIT freezes round_key/round_idx; no timeout, no combinational ready path.
module inv_key_scheduler (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] cipher_key,
    output logic         busy,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    // AES S-box, byte 0 in the leftmost position.
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    // RotWord followed by SubWord on every byte.
    function automatic logic [31:0] g_function(input logic [31:0] w);
        logic [31:0] rot;
        rot = {w[23:0], w[31:24]};
        return {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    endfunction

    // Round constant high byte, looked up directly by round number.
    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t       state_q;
    logic [0:127] key_q;
    logic [3:0]   cnt_q;     // round r while expanding, idx while emitting

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] g_in, g_out, rc;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] i0, i1, i2, i3;

    assign w0 = key_q[0:31];
    assign w1 = key_q[32:63];
    assign w2 = key_q[64:95];
    assign w3 = key_q[96:127];

    // Single G instance: forward step uses w3, inverse step uses the recovered w3'.
    assign g_in  = (state_q == EMIT) ? (w3 ^ w2) : w3;
    assign g_out = g_function(g_in);
    assign rc    = {rcon_byte(cnt_q), 24'h000000};

    assign f0 = w0 ^ g_out ^ rc;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ g_out ^ rc;

    assign round_key = key_q;
    assign round_idx = cnt_q;

    // Control FSM and key register; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_q     <= '0;
            cnt_q     <= 4'd0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_q   <= cipher_key;
                        cnt_q   <= 4'd1;
                        busy    <= 1'b1;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_q <= {f0, f1, f2, f3};
                    if (cnt_q == 4'd10) begin
                        state_q <= EMIT;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                EMIT: begin
                    // First EMIT cycle only raises valid; handshakes start after that.
                    if (!key_valid) begin
                        key_valid <= 1'b1;
                    end else if (key_ready) begin
                        if (cnt_q != 4'd0) begin
                            key_q <= {i0, i1, i2, i3};
                            cnt_q <= cnt_q - 4'd1;
                        end else begin
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_scheduler.sv
module tb_inv_key_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    int tests = 0;
    int fails = 0;

    inv_key_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cipher_key(cipher_key),
        .busy(busy), .key_valid(key_valid), .key_ready(key_ready),
        .round_key(round_key), .round_idx(round_idx), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (GF(2^8) arithmetic, plain key expansion) ----------------
    logic [7:0]   m_sbox [256];
    logic [127:0] m_rk   [11];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox;
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers ----------------
    logic [127:0] c_keys [11];
    logic [3:0]   c_idx  [11];
    int c_n, c_cyc, c_stab, c_bd, c_ov;
    bit c_done, c_to;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start accepted at edge 0; returns just after edge 10. Optional second start at edge 3.
    task automatic launch(input logic [127:0] k, input bit poke3, input logic [127:0] pk);
        start = 1'b1;
        cipher_key = k;
        tick;
        start = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            if (poke3 && e == 3) begin
                start = 1'b1;
                cipher_key = pk;
            end
            tick;
            start = 1'b0;
        end
    endtask

    // Records accepted keys until the done cycle; ready high with probability pct%.
    task automatic collect(input int pct, input int poke, input logic [127:0] pk);
        logic [127:0] pkey;
        logic [3:0]   pidx;
        bit stall;
        c_n = 0; c_cyc = 0; c_stab = 0; c_bd = 0; c_ov = 0; c_done = 0; c_to = 0;
        stall = 0; pkey = '0; pidx = '0;
        while (1) begin
            if (done) begin
                c_done = 1;
                if (key_valid) c_ov++;
                break;
            end
            if (c_cyc >= 300) begin
                c_to = 1;
                break;
            end
            if (!busy) c_bd++;
            if (stall && (round_key !== pkey || round_idx !== pidx)) c_stab++;
            key_ready = ($urandom_range(99) < pct);
            if (key_valid && key_ready && c_n < 11) begin
                c_keys[c_n] = round_key;
                c_idx[c_n]  = round_idx;
                c_n++;
            end
            stall = key_valid && !key_ready;
            pkey = round_key;
            pidx = round_idx;
            if (c_cyc == poke) begin
                start = 1'b1;
                cipher_key = pk;
            end
            tick;
            start = 1'b0;
            c_cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; cipher_key = '0;
        #3;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (round_key !== 128'h0) begin fails++; $display("FAIL reset_key: got %h expected 0", round_key); end
        tests++; if (round_idx !== 4'd0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", round_idx); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick;
    endtask

    task automatic test_fips;
        logic [127:0] k;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(k);
        key_ready = 1'b1;
        launch(k, 0, '0);
        tests++; if (busy !== 1'b1 || key_valid !== 1'b0) begin fails++; $display("FAIL fips_edge10: got busy=%b valid=%b expected busy=1 valid=0", busy, key_valid); end
        tick;
        tests++; if (key_valid !== 1'b1 || round_idx !== 4'd10) begin fails++; $display("FAIL fips_edge11: got valid=%b idx=%0d expected valid=1 idx=10", key_valid, round_idx); end
        tests++; if (round_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin fails++; $display("FAIL fips_rk10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", round_key); end
        collect(100, -1, '0);
        tests++; if (c_to || c_n != 11) begin fails++; $display("FAIL fips_count: got %0d keys timeout=%b expected 11", c_n, c_to); end
        tests++; if (c_keys[1] !== 128'hac7766f319fadc2128d12941575c006e || c_idx[1] !== 4'd9) begin fails++; $display("FAIL fips_rk9: got %h idx %0d expected ac7766f319fadc2128d12941575c006e idx 9", c_keys[1], c_idx[1]); end
        tests++; if (c_keys[9] !== 128'ha0fafe1788542cb123a339392a6c7605) begin fails++; $display("FAIL fips_rk1: got %h expected a0fafe1788542cb123a339392a6c7605", c_keys[9]); end
        tests++; if (c_keys[10] !== k || c_idx[10] !== 4'd0) begin fails++; $display("FAIL fips_rk0: got %h idx %0d expected %h idx 0", c_keys[10], c_idx[10], k); end
        for (int j = 0; j < 11; j++) begin
            tests++;
            if (c_keys[j] !== m_rk[10-j] || c_idx[j] !== 4'(10-j)) begin
                fails++; $display("FAIL fips_seq[%0d]: got %h idx %0d expected %h idx %0d", j, c_keys[j], c_idx[j], m_rk[10-j], 10-j);
            end
        end
        tests++; if (c_cyc != 11 || c_ov != 0 || busy !== 1'b0) begin fails++; $display("FAIL fips_done_timing: got cycles=%0d overlap=%0d busy=%b expected 11 0 0", c_cyc, c_ov, busy); end
        tick;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL fips_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_backpressure;
        logic [127:0] k;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(k);
        launch(k, 0, '0);
        tick;
        collect(45, -1, '0);
        tests++; if (c_to || c_n != 11 || !c_done) begin fails++; $display("FAIL bp_count: got %0d keys timeout=%b expected 11", c_n, c_to); end
        tests++; if (c_stab != 0) begin fails++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", c_stab); end
        for (int j = 0; j < 11; j++) begin
            tests++;
            if (c_keys[j] !== m_rk[10-j] || c_idx[j] !== 4'(10-j)) begin
                fails++; $display("FAIL bp_seq[%0d]: got %h idx %0d expected %h idx %0d", j, c_keys[j], c_idx[j], m_rk[10-j], 10-j);
            end
        end
        tick;
    endtask

    task automatic test_ignored_start;
        logic [127:0] k, other;
        k = {$urandom, $urandom, $urandom, $urandom};
        other = ~k;
        model_expand(k);
        key_ready = 1'b1;
        launch(k, 1, other);
        tick;
        collect(100, 3, other);
        tests++; if (c_bd != 0 || c_to) begin fails++; $display("FAIL ign_busy: got %0d cycles with busy low expected 0", c_bd); end
        for (int j = 0; j < 11; j++) begin
            tests++;
            if (c_keys[j] !== m_rk[10-j] || c_idx[j] !== 4'(10-j)) begin
                fails++; $display("FAIL ign_seq[%0d]: got %h idx %0d expected %h idx %0d", j, c_keys[j], c_idx[j], m_rk[10-j], 10-j);
            end
        end
        tick;
    endtask

    task automatic test_midrun_reset;
        logic [127:0] k;
        int guard;
        k = {$urandom, $urandom, $urandom, $urandom};
        key_ready = 1'b1;
        launch(k, 0, '0);
        tick;
        guard = 0;
        while (round_idx !== 4'd6 && guard < 20) begin
            tick;
            guard++;
        end
        tests++; if (round_idx !== 4'd6 || key_valid !== 1'b1) begin fails++; $display("FAIL rst_reach6: got idx %0d valid %b expected 6 1", round_idx, key_valid); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || key_valid !== 1'b0 || done !== 1'b0 || round_key !== 128'h0 || round_idx !== 4'd0) begin
            fails++; $display("FAIL rst_outputs: got busy=%b valid=%b done=%b key=%h idx=%0d expected all 0", busy, key_valid, done, round_key, round_idx);
        end
        #2 rst_n = 1'b1;
        tick;
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        launch(k, 0, '0);
        tick;
        collect(100, -1, '0);
        for (int j = 0; j < 11; j++) begin
            tests++;
            if (c_keys[j] !== m_rk[10-j] || c_idx[j] !== 4'(10-j)) begin
                fails++; $display("FAIL rst_seq[%0d]: got %h idx %0d expected %h idx %0d", j, c_keys[j], c_idx[j], m_rk[10-j], 10-j);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] k2;
        k2 = 128'h000102030405060708090a0b0c0d0e0f;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_in_done: got done=%b expected 1", done); end
        model_expand(k2);
        key_ready = 1'b1;
        launch(k2, 0, '0);
        tick;
        tests++; if (key_valid !== 1'b1 || round_idx !== 4'd10 || round_key !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            fails++; $display("FAIL b2b_rk10: got valid=%b idx=%0d key=%h expected 1 10 13111d7fe3944a17f307a78b4d2b30c5", key_valid, round_idx, round_key);
        end
        collect(100, -1, '0);
        tests++; if (c_n != 11 || c_keys[10] !== k2 || c_idx[10] !== 4'd0) begin fails++; $display("FAIL b2b_rk0: got %h idx %0d expected %h idx 0", c_keys[10], c_idx[10], k2); end
        for (int j = 0; j < 11; j++) begin
            tests++;
            if (c_keys[j] !== m_rk[10-j]) begin
                fails++; $display("FAIL b2b_seq[%0d]: got %h expected %h", j, c_keys[j], m_rk[10-j]);
            end
        end
    endtask

    task automatic test_random;
        logic [127:0] k;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            launch(k, 0, '0);
            tick;
            collect((i % 4 == 0) ? 60 : 100, -1, '0);
            ok = !c_to && c_done && (c_n == 11) && (c_stab == 0);
            for (int j = 0; j < 11; j++)
                if (j < c_n && (c_keys[j] !== m_rk[10-j] || c_idx[j] !== 4'(10-j))) ok = 0;
            tests++;
            if (!ok) begin
                fails++; $display("FAIL rand_key[%0d]: key %h got %0d keys, first %h, expected 11 keys, first %h", i, k, c_n, c_keys[0], m_rk[10]);
            end
        end
    endtask

    initial begin
        build_sbox;
        test_reset;
        test_fips;
        test_backpressure;
        test_ignored_start;
        test_midrun_reset;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
